// File: rtl/mux_scan_ctrl_if.sv
// Load handshake and serialiser outputs between the mux scan sequencer and its neighbours.
// The master side feeds bytes and abort; the slave side is the sequencer itself.
interface mux_scan_ctrl_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       abort;
    logic [7:0] mux_in;
    logic [2:0] sel;
    logic       bit_valid;
    logic       bit_strobe;
    logic       bit_last;
    logic       busy;
    logic       done;

    modport master (
        output load_valid, load_data, abort,
        input  load_ready, mux_in, sel, bit_valid, bit_strobe, bit_last, busy, done
    );

    modport slave (
        input  load_valid, load_data, abort,
        output load_ready, mux_in, sel, bit_valid, bit_strobe, bit_last, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer in front of an 8:1 mux: latches a byte, then walks sel across all eight
// inputs, holding each index DIV clocks, so the mux output becomes a serial bit stream.
module mux_scan_ctrl #(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);

    generate
        if (DIV < 1 || DIV > 255) begin : g_divCheck
            $error("mux_scan_ctrl: DIV must be in 1..255");
        end
    endgenerate

    localparam logic [2:0] START     = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] FINAL     = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [7:0] LAST_TICK = 8'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t     r_state,      w_nextState;
    logic [7:0] r_prescale,   w_nextPrescale;
    logic [7:0] r_muxIn,      w_nextMuxIn;
    logic [2:0] r_sel,        w_nextSel;
    logic       r_loadReady,  w_nextLoadReady;
    logic       r_bitValid,   w_nextBitValid;
    logic       r_bitStrobe,  w_nextBitStrobe;
    logic       r_bitLast,    w_nextBitLast;
    logic       r_busy,       w_nextBusy;
    logic       r_done,       w_nextDone;
    logic [2:0] w_selStep;

    assign w_selStep = MSB_FIRST ? (r_sel - 3'd1) : (r_sel + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prescale  <= 8'd0;
            r_muxIn     <= 8'd0;
            r_sel       <= START;
            r_loadReady <= 1'b1;
            r_bitValid  <= 1'b0;
            r_bitStrobe <= 1'b0;
            r_bitLast   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_prescale  <= w_nextPrescale;
            r_muxIn     <= w_nextMuxIn;
            r_sel       <= w_nextSel;
            r_loadReady <= w_nextLoadReady;
            r_bitValid  <= w_nextBitValid;
            r_bitStrobe <= w_nextBitStrobe;
            r_bitLast   <= w_nextBitLast;
            r_busy      <= w_nextBusy;
            r_done      <= w_nextDone;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextPrescale  = r_prescale;
        w_nextMuxIn     = r_muxIn;
        w_nextSel       = r_sel;
        w_nextLoadReady = r_loadReady;
        w_nextBitValid  = r_bitValid;
        w_nextBitStrobe = r_bitStrobe;
        w_nextBitLast   = r_bitLast;
        w_nextBusy      = r_busy;
        w_nextDone      = r_done;

        unique case (r_state)
            IDLE: begin
                if (bus.load_valid && r_loadReady) begin
                    w_nextMuxIn     = bus.load_data;
                    w_nextSel       = START;
                    w_nextPrescale  = 8'd0;
                    w_nextBusy      = 1'b1;
                    w_nextBitValid  = 1'b1;
                    w_nextBitStrobe = 1'b1;
                    w_nextBitLast   = 1'b0;
                    w_nextLoadReady = 1'b0;
                    w_nextState     = SHIFT;
                end
            end
            SHIFT: begin
                // abort wins over stepping and finishing, including on the very last cycle
                if (bus.abort) begin
                    w_nextState     = IDLE;
                    w_nextPrescale  = 8'd0;
                    w_nextSel       = START;
                    w_nextLoadReady = 1'b1;
                    w_nextBitValid  = 1'b0;
                    w_nextBitStrobe = 1'b0;
                    w_nextBitLast   = 1'b0;
                    w_nextBusy      = 1'b0;
                end else if (r_prescale == LAST_TICK) begin
                    w_nextPrescale = 8'd0;
                    if (r_sel == FINAL) begin
                        w_nextBitValid  = 1'b0;
                        w_nextBitStrobe = 1'b0;
                        w_nextBitLast   = 1'b0;
                        w_nextBusy      = 1'b0;
                        w_nextDone      = 1'b1;
                        w_nextState     = DONE;
                    end else begin
                        w_nextSel       = w_selStep;
                        w_nextBitStrobe = 1'b1;
                        w_nextBitLast   = (w_selStep == FINAL);
                    end
                end else begin
                    w_nextPrescale  = r_prescale + 8'd1;
                    w_nextBitStrobe = 1'b0;
                end
            end
            DONE: begin
                w_nextDone      = 1'b0;
                w_nextLoadReady = 1'b1;
                w_nextSel       = START;
                w_nextState     = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign bus.load_ready = r_loadReady;
    assign bus.mux_in     = r_muxIn;
    assign bus.sel        = r_sel;
    assign bus.bit_valid  = r_bitValid;
    assign bus.bit_strobe = r_bitStrobe;
    assign bus.bit_last   = r_bitLast;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
